// File: rtl/aqp_ebus_arbiter.sv
// Purpose: arbitrates NUM_MASTERS internal masters onto the external Z80 bus (ebus),
//          with BUSREQ#/BUSACK# handshake, turnaround cycle and RD#/WR# strobe detection.
// Latency: grant 2 cycles after request (or after synchronised BUSACK#); bus_* 1 cycle behind owner.
// Backpressure: requesters wait on m_gnt; an owner keeps the bus until it drops m_req.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   has_z80                     physical Z80 fitted (static after reset)
//   m_req / m_gnt               per-master request, one-hot registered grant
//   m_a, m_rd_n, m_wr_n,        per-master address / strobes / write data,
//   m_mreq_n, m_iorq_n,         packed master i at [16i+15:16i] (address)
//   m_wrdata, m_wrdata_en       and [8i+7:8i] (data)
//   ebus_busreq_n, ebus_busack_n  Z80 bus request (push-pull) / raw bus acknowledge
//   bus_oe, bus_a, bus_*_n      muxed address/controls and their drive enable
//   bus_d_out, bus_d_oe         muxed write data and its drive enable
//   ebus_rd_n_in, ebus_wr_n_in  raw bus strobes
//   bus_read, bus_write         one-cycle pulses on each falling strobe edge
//   ack_timeout                 one-cycle pulse when BUSACK# never arrived
module aqp_ebus_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int RR_MODE     = 0,
  parameter int SYNC_STAGES = 2,
  parameter int ACK_TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      has_z80,
  input  logic [NUM_MASTERS-1:0]    m_req,
  output logic [NUM_MASTERS-1:0]    m_gnt,
  input  logic [16*NUM_MASTERS-1:0] m_a,
  input  logic [NUM_MASTERS-1:0]    m_rd_n,
  input  logic [NUM_MASTERS-1:0]    m_wr_n,
  input  logic [NUM_MASTERS-1:0]    m_mreq_n,
  input  logic [NUM_MASTERS-1:0]    m_iorq_n,
  input  logic [8*NUM_MASTERS-1:0]  m_wrdata,
  input  logic [NUM_MASTERS-1:0]    m_wrdata_en,
  output logic                      ebus_busreq_n,
  input  logic                      ebus_busack_n,
  output logic                      bus_oe,
  output logic [15:0]               bus_a,
  output logic                      bus_rd_n,
  output logic                      bus_wr_n,
  output logic                      bus_mreq_n,
  output logic                      bus_iorq_n,
  output logic [7:0]                bus_d_out,
  output logic                      bus_d_oe,
  input  logic                      ebus_rd_n_in,
  input  logic                      ebus_wr_n_in,
  output logic                      bus_read,
  output logic                      bus_write,
  output logic                      ack_timeout
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
  // Counter value on the cycle before it would reach ACK_TIMEOUT.
  localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ACK,
    ST_ARB,
    ST_GRANT,
    ST_TURN
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] busack_sync;
  logic [SYNC_STAGES:0]   rd_sh, wr_sh;
  logic                   busack_s;
  logic [CW-1:0]          ack_cnt;
  logic                   ack_fire;
  logic                   any_req;
  logic                   found;
  logic [IW-1:0]          win_sel;
  logic [IW-1:0]          win;
  // rr_ptr is the index searched first; 0 after reset so master 0 wins the first round.
  logic [IW-1:0]          rr_ptr;

  logic                   sel_req, sel_rd_n, sel_wr_n, sel_mreq_n, sel_iorq_n, sel_d_en;
  logic [15:0]            sel_a;
  logic [7:0]             sel_d;

  // ---------------------------------------------------------------------------
  // Synchronisers and strobe edge detectors
  // ---------------------------------------------------------------------------
  assign busack_s = busack_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      busack_sync <= '1;
      rd_sh       <= '1;
      wr_sh       <= '1;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
    end else begin
      busack_sync <= {busack_sync[SYNC_STAGES-2:0], ebus_busack_n};
      rd_sh       <= {rd_sh[SYNC_STAGES-1:0], ebus_rd_n_in};
      wr_sh       <= {wr_sh[SYNC_STAGES-1:0], ebus_wr_n_in};
      // Older stage high, synchronised stage low: exactly one pulse per falling edge.
      bus_read    <= rd_sh[SYNC_STAGES] & ~rd_sh[SYNC_STAGES-1];
      bus_write   <= wr_sh[SYNC_STAGES] & ~wr_sh[SYNC_STAGES-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Winner selection: search from rr_ptr upward first (round-robin only),
  // then fall back to the lowest set index, which also covers the wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    any_req = |m_req;
    found   = 1'b0;
    win_sel = '0;
    if (RR_MODE != 0) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && m_req[i] && (IW'(i) >= rr_ptr)) begin
          found   = 1'b1;
          win_sel = IW'(i);
        end
      end
    end
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!found && m_req[i]) begin
        found   = 1'b1;
        win_sel = IW'(i);
      end
    end
  end

  // Signals of the current owner.
  always_comb begin
    sel_req    = 1'b0;
    sel_a      = '0;
    sel_rd_n   = 1'b1;
    sel_wr_n   = 1'b1;
    sel_mreq_n = 1'b1;
    sel_iorq_n = 1'b1;
    sel_d      = '0;
    sel_d_en   = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (win == IW'(i)) begin
        sel_req    = m_req[i];
        sel_a      = m_a[16*i +: 16];
        sel_rd_n   = m_rd_n[i];
        sel_wr_n   = m_wr_n[i];
        sel_mreq_n = m_mreq_n[i];
        sel_iorq_n = m_iorq_n[i];
        sel_d      = m_wrdata[8*i +: 8];
        sel_d_en   = m_wrdata_en[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ack_fire  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = has_z80 ? ST_WAIT_ACK : ST_ARB;
        end
      end
      ST_WAIT_ACK: begin
        if (!busack_s) begin
          state_nxt = ST_ARB;
        end else if (!any_req) begin
          state_nxt = ST_IDLE;
        end else if ((ACK_TIMEOUT != 0) && (ack_cnt == TO_LAST)) begin
          state_nxt = ST_IDLE;
          ack_fire  = 1'b1;
        end
      end
      ST_ARB: begin
        state_nxt = any_req ? ST_GRANT : ST_IDLE;
      end
      ST_GRANT: begin
        // No pre-emption: only the owner dropping its request ends the grant.
        if (!sel_req) begin
          state_nxt = ST_TURN;
        end
      end
      ST_TURN: begin
        state_nxt = any_req ? ST_ARB : ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_cnt       <= '0;
      ack_timeout   <= 1'b0;
      ebus_busreq_n <= 1'b1;
      m_gnt         <= '0;
      win           <= '0;
      rr_ptr        <= '0;
      bus_oe        <= 1'b0;
      bus_a         <= '0;
      bus_rd_n      <= 1'b1;
      bus_wr_n      <= 1'b1;
      bus_mreq_n    <= 1'b1;
      bus_iorq_n    <= 1'b1;
      bus_d_out     <= '0;
      bus_d_oe      <= 1'b0;
    end else begin
      ack_cnt     <= (state == ST_WAIT_ACK) ? ack_cnt + CW'(1) : '0;
      ack_timeout <= ack_fire;
      // BUSREQ# is held for the whole session, from WAIT_ACK until back in IDLE.
      ebus_busreq_n <= ~(has_z80 && (state_nxt != ST_IDLE));

      if ((state == ST_ARB) && (state_nxt == ST_GRANT)) begin
        win    <= win_sel;
        rr_ptr <= (win_sel == LAST_IDX) ? '0 : win_sel + IW'(1);
        m_gnt  <= NUM_MASTERS'(1) << win_sel;
        bus_oe <= 1'b1;
      end

      if (state == ST_GRANT) begin
        if (state_nxt == ST_TURN) begin
          m_gnt      <= '0;
          bus_rd_n   <= 1'b1;
          bus_wr_n   <= 1'b1;
          bus_mreq_n <= 1'b1;
          bus_iorq_n <= 1'b1;
          bus_d_oe   <= 1'b0;
        end else begin
          bus_a      <= sel_a;
          bus_rd_n   <= sel_rd_n;
          bus_wr_n   <= sel_wr_n;
          bus_mreq_n <= sel_mreq_n;
          bus_iorq_n <= sel_iorq_n;
          bus_d_out  <= sel_d;
          bus_d_oe   <= sel_d_en;
        end
      end

      // Idle strobes stay driven through TURN and ARB so the bus never floats
      // between owners; the drivers only let go once the session ends.
      if (state_nxt == ST_IDLE) begin
        bus_oe <= 1'b0;
        m_gnt  <= '0;
      end
    end
  end

endmodule
